seq_checker: RTL and testbench
==============================

SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 Parameter STEP, default 1: expected increment between consecutive samples, modulo 256.
REQ-002 Parameter LOCK_CNT, default 4: consecutive in-sequence samples needed to declare lock; legal range 2..15.
REQ-003 Parameter LOSS_CNT, default 2: consecutive mismatches while locked that drop lock; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 sync_clr  input  1  synchronous clear of all state and counters.
REQ-007 in_valid  input  1  seq_in carries a sample this cycle.
REQ-008 seq_in  input  8  sample from the upstream sequence generator output.
REQ-009 locked  output  1  checker is locked to the incoming sequence.
REQ-010 err_pulse  output  1  one-cycle pulse per mismatching sample while locked.
REQ-011 err_count  output  16  count of mismatches while locked.

Function
REQ-012 States SHALL be IDLE (no reference), HUNT (acquiring), LOCKED; registers: exp[7:0], good_run[3:0], bad_run[3:0].
REQ-013 Cycles with in_valid=0 SHALL leave state, exp, run counters and outputs unchanged, except err_pulse, which returns to 0.
REQ-014 IDLE + valid: exp <= seq_in+STEP, good_run <= 1, go to HUNT.
REQ-015 HUNT + valid + (seq_in==exp): good_run++, exp <= seq_in+STEP; if the new good_run equals LOCK_CNT, go to LOCKED with bad_run <= 0.
REQ-016 HUNT + valid + mismatch: resync with exp <= seq_in+STEP and good_run <= 1; no error is reported.
REQ-017 LOCKED + valid + match: bad_run <= 0, exp <= seq_in+STEP.
REQ-018 LOCKED + valid + mismatch: err_pulse=1 next cycle, err_count++, bad_run++, exp <= exp+STEP (flywheel, no resync).
REQ-019 LOCKED mismatch where the new bad_run equals LOSS_CNT: go to HUNT with good_run <= 1 and exp <= seq_in+STEP; that sample's error is still counted.
REQ-020 All arithmetic on exp SHALL be modulo 256 (255+1 yields 0, with no error).
REQ-021 locked SHALL equal (state==LOCKED) from a register; locked and err_pulse change 1 cycle after the deciding sample.
REQ-022 err_count SHALL saturate at 16'hFFFF.
REQ-023 sync_clr=1 SHALL force IDLE and clear all counters and outputs next cycle; it wins over a simultaneous in_valid, and that sample is dropped.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, with exp=0, good_run=0, bad_run=0, locked=0, err_pulse=0 and err_count=0, regardless of clk.
REQ-025 After rst deasserts, the first valid sample SHALL be treated as in IDLE; rst asserted mid-lock discards all history.

Configuration
REQ-026 Macro SEQ_CHECKER_ERRCNT_EN defined: err_count SHALL be implemented per REQ-018/022/023.
REQ-027 Macro SEQ_CHECKER_ERRCNT_EN undefined: no counter register; err_count SHALL be constant 0; locked and err_pulse behaviour is unchanged.

Verification (STEP=1, LOCK_CNT=4, LOSS_CNT=2, SEQ_CHECKER_ERRCNT_EN defined)
REQ-028 rst, then samples 0,1,2,...,7 on consecutive cycles -> locked rises the cycle after sample 3 and stays high; err_pulse never 1; err_count=0.
REQ-029 Locked, then samples 10,11,99,13,14 -> one err_pulse after 99, err_count=1, locked stays 1.
REQ-030 Locked, then samples 10,11,50,60,61,62,63 -> err_pulse after 50 and after 60, err_count=2, locked falls after 60 and rises again after 63.
REQ-031 Samples 250..255,0,1,2 with in_valid gaps of 0-3 idle cycles -> lock achieved, no errors across the wrap, state frozen during gaps.
REQ-032 Locked with err_count=2: assert sync_clr together with a valid sample -> next cycle locked=0, err_count=0, state IDLE; assert rst mid-lock -> outputs 0 immediately, before the next edge.

Source files
------------

// File: rtl/seq_checker.sv
// Sequence checker: hunts for, locks onto and monitors an incrementing 8-bit sample stream.
// Define SEQ_CHECKER_ERRCNT_EN to build the saturating mismatch counter; otherwise err_count is tied to 0.
module seq_checker #(
  parameter int STEP     = 1,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sync_clr,
  input  logic        in_valid,
  input  logic [7:0]  seq_in,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count
);

  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] STEP_V = STEP[DATA_W-1:0];
  localparam logic [3:0]        LOCK_N = LOCK_CNT[3:0];
  localparam logic [3:0]        LOSS_N = LOSS_CNT[3:0];

  typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   exp_q, exp_d;
  logic [3:0]          good_run_q, good_run_d;
  logic [3:0]          bad_run_q, bad_run_d;
  logic                err_pulse_q, err_pulse_d;

  // Wraps naturally at the 8-bit width, so 255 + 1 expects 0.
  function automatic logic [DATA_W-1:0] next_exp(input logic [DATA_W-1:0] v);
    return v + STEP_V;
  endfunction

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    good_run_d  = good_run_q;
    bad_run_d   = bad_run_q;
    err_pulse_d = 1'b0;
    if (sync_clr) begin
      state_d    = IDLE;
      exp_d      = '0;
      good_run_d = '0;
      bad_run_d  = '0;
    end else if (in_valid) begin
      unique case (state_q)
        IDLE: begin
          exp_d      = next_exp(seq_in);
          good_run_d = 4'd1;
          state_d    = HUNT;
        end
        HUNT: begin
          exp_d = next_exp(seq_in);
          if (seq_in == exp_q) begin
            good_run_d = good_run_q + 4'd1;
            if (good_run_q + 4'd1 == LOCK_N) begin
              state_d   = LOCKED;
              bad_run_d = '0;
            end
          end else begin
            good_run_d = 4'd1;
          end
        end
        LOCKED: begin
          if (seq_in == exp_q) begin
            bad_run_d = '0;
            exp_d     = next_exp(seq_in);
          end else begin
            err_pulse_d = 1'b1;
            bad_run_d   = bad_run_q + 4'd1;
            exp_d       = next_exp(exp_q);
            // Too many misses in a row: abandon the flywheel and resync on this sample.
            if (bad_run_q + 4'd1 == LOSS_N) begin
              state_d    = HUNT;
              good_run_d = 4'd1;
              exp_d      = next_exp(seq_in);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      exp_q       <= '0;
      good_run_q  <= '0;
      bad_run_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      good_run_q  <= good_run_d;
      bad_run_q   <= bad_run_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;

`ifdef SEQ_CHECKER_ERRCNT_EN
  logic [15:0] err_count_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              err_count_q <= '0;
    else if (sync_clr)    err_count_q <= '0;
    else if (err_pulse_d) err_count_q <= sat_inc(err_count_q);
  end

  assign err_count = err_count_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_seq_checker.sv
// Directed, table-driven bench for seq_checker (STEP=1, LOCK_CNT=4, LOSS_CNT=2).
module tb_seq_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        sync_clr;
  logic        in_valid;
  logic [7:0]  seq_in;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;

  int n_checks = 0;
  int n_fails  = 0;

  seq_checker #(.STEP(1), .LOCK_CNT(4), .LOSS_CNT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .sync_clr  (sync_clr),
    .in_valid  (in_valid),
    .seq_in    (seq_in),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        vld;
    logic [7:0]  d;
    logic        e_locked;
    logic        e_pulse;
    logic [15:0] e_cnt;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] ec(input logic [15:0] v);
`ifdef SEQ_CHECKER_ERRCNT_EN
    return v;
`else
    return 16'd0 & v;
`endif
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_outs(input string name, input logic l, input logic p, input logic [15:0] c);
    check({name, ".locked"},    {15'd0, locked},    {15'd0, l});
    check({name, ".err_pulse"}, {15'd0, err_pulse}, {15'd0, p});
    check({name, ".err_count"}, err_count,          ec(c));
  endtask

  task automatic apply(input logic clr, input logic vld, input logic [7:0] d);
    sync_clr = clr;
    in_valid = vld;
    seq_in   = d;
    @(posedge clk);
    #1;
    sync_clr = 1'b0;
    in_valid = 1'b0;
  endtask

  function automatic void add(input logic clr, input logic vld, input logic [7:0] d,
                              input logic l, input logic p, input logic [15:0] c, input string n);
    vec_t v;
    v.clr = clr; v.vld = vld; v.d = d;
    v.e_locked = l; v.e_pulse = p; v.e_cnt = c; v.name = n;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [7:0] gap_samp[9];
    logic       prev_locked;

    // Clean lock on 0..7: lock after sample 3.
    for (int i = 0; i < 8; i++) add(0, 1, 8'(i), (i >= 3), 0, 0, "lock_run");
    // Isolated miss while locked, then a gap that must clear err_pulse.
    add(0, 1, 8'd8,  1, 0, 0, "locked_8");
    add(0, 1, 8'd9,  1, 0, 0, "locked_9");
    add(0, 1, 8'd10, 1, 0, 0, "locked_10");
    add(0, 1, 8'd11, 1, 0, 0, "locked_11");
    add(0, 1, 8'd99, 1, 1, 1, "miss_99");
    add(0, 0, 8'd0,  1, 0, 1, "gap_after_miss");
    add(0, 1, 8'd13, 1, 0, 1, "flywheel_13");
    add(0, 1, 8'd14, 1, 0, 1, "locked_14");
    add(1, 0, 8'd0,  0, 0, 0, "sync_clr");
    // Two consecutive misses drop lock; resync and relock on 60..63.
    add(0, 1, 8'd6,  0, 0, 0, "hunt_6");
    add(0, 1, 8'd7,  0, 0, 0, "hunt_7");
    add(0, 1, 8'd8,  0, 0, 0, "hunt_8");
    add(0, 1, 8'd9,  1, 0, 0, "relock_9");
    add(0, 1, 8'd10, 1, 0, 0, "l2_10");
    add(0, 1, 8'd11, 1, 0, 0, "l2_11");
    add(0, 1, 8'd50, 1, 1, 1, "miss_50");
    add(0, 1, 8'd60, 0, 1, 2, "loss_60");
    add(0, 1, 8'd61, 0, 0, 2, "hunt_61");
    add(0, 1, 8'd62, 0, 0, 2, "hunt_62");
    add(0, 1, 8'd63, 1, 0, 2, "relock_63");
    // sync_clr beats a simultaneous valid; 64 is dropped so lock needs 65..68.
    add(1, 1, 8'd64, 0, 0, 0, "clr_with_valid");
    add(0, 1, 8'd65, 0, 0, 0, "idle_65");
    add(0, 1, 8'd66, 0, 0, 0, "hunt_66");
    add(0, 1, 8'd67, 0, 0, 0, "hunt_67");
    add(0, 1, 8'd68, 1, 0, 0, "lock_68");

    rst = 1'b1; sync_clr = 1'b0; in_valid = 1'b0; seq_in = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i].clr, vecs[i].vld, vecs[i].d);
      check_outs(vecs[i].name, vecs[i].e_locked, vecs[i].e_pulse, vecs[i].e_cnt);
    end

    // Wrap-around 250..255,0,1,2 with 0-3 idle cycles between samples.
    apply(1, 0, 8'd0);
    for (int i = 0; i < 9; i++) gap_samp[i] = 8'(250 + i);
    for (int i = 0; i < 9; i++) begin
      apply(0, 1, gap_samp[i]);
      check_outs("wrap_sample", (i >= 3), 0, 0);
      prev_locked = locked;
      for (int g = 0; g < (i % 4); g++) begin
        apply(0, 0, 8'hA5);
        check_outs("wrap_gap", prev_locked, 0, 0);
      end
    end

    // Miss, then asynchronous reset mid-lock clears everything before the next edge.
    apply(0, 1, 8'd200);
    check_outs("pre_rst_miss", 1, 1, 1);
    rst = 1'b1;
    #2;
    check_outs("async_rst", 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // History discarded: 3 (which the old lock expected) starts a fresh hunt.
    apply(0, 1, 8'd3);
    check_outs("post_rst_3", 0, 0, 0);
    apply(0, 1, 8'd4);
    apply(0, 1, 8'd5);
    check_outs("post_rst_5", 0, 0, 0);
    apply(0, 1, 8'd6);
    check_outs("post_rst_lock", 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
